// File: rtl/game_pkg.sv
// Shared types and defaults for the dinosaur-game flow controller.
package game_pkg;

    localparam int unsigned STATE_W     = 3;
    localparam int unsigned SCORE_W_DEF = 16;
    localparam int unsigned NUM_OBS_DEF = 4;

    typedef enum logic [STATE_W-1:0] {
        MENU         = 3'd0,
        S_RESET      = 3'd1,
        S_GEN_SCREEN = 3'd2,
        GAME         = 3'd3,
        PAUSE        = 3'd4,
        S_CALC_HS    = 3'd5,
        S_SCORE      = 3'd6
    } state_t;

endpackage

// File: rtl/obs_slot_alloc.sv
// Obstacle-slot allocator: grants the lowest free slot on gen, frees slots on obs_done.
// Allocation looks at the occupancy mask as it stood before this cycle's obs_done.
module obs_slot_alloc
    import game_pkg::*;
#(
    parameter int unsigned NUM_OBS = NUM_OBS_DEF
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic               gen,
    input  logic [NUM_OBS-1:0] obs_done,
    output logic [NUM_OBS-1:0] spawn,
    output logic [NUM_OBS-1:0] active,
    output logic               drop
);

    logic [NUM_OBS-1:0] r_active;
    logic [NUM_OBS-1:0] r_spawn;
    logic               r_drop;
    logic [NUM_OBS-1:0] w_pick;
    logic               w_found;

    // Priority encoder: one-hot of the lowest-index free slot
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = 0; i < int'(NUM_OBS); i++) begin
            if (!r_active[i] && !w_found) begin
                w_pick[i] = 1'b1;
                w_found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= '0;
            r_spawn  <= '0;
            r_drop   <= 1'b0;
        end else if (clr) begin
            r_active <= '0;
            r_spawn  <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_spawn <= '0;
            r_drop  <= 1'b0;
            if (en) begin
                r_active <= (r_active & ~obs_done) | ((gen && w_found) ? w_pick : '0);
                r_spawn  <= (gen && w_found) ? w_pick : '0;
                r_drop   <= gen && !w_found;
            end
        end
    end

    assign spawn  = r_spawn;
    assign active = r_active;
    assign drop   = r_drop;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level dinosaur-game flow FSM with tick divider, jump timer, score and obstacle slots.
// Define GAME_HISCORE_EN to keep a persistent high score; otherwise hi_score is tied to 0.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned SCORE_W    = SCORE_W_DEF,
    parameter int unsigned NUM_OBS    = NUM_OBS_DEF,
    parameter int unsigned TICK_DIV   = 833333,
    parameter int unsigned JUMP_TICKS = 24,
    parameter int unsigned CLR_CYCLES = 19200
)(
    input  logic               Clock,
    input  logic               resetn,
    input  logic               play,
    input  logic               view_score,
    input  logic               ret,
    input  logic               jump,
    input  logic               pause,
    input  logic               gen,
    input  logic               lose,
    input  logic [NUM_OBS-1:0] obs_done,
    output logic [STATE_W-1:0] state,
    output logic               clr_screen,
    output logic               draw_en,
    output logic               tick,
    output logic               jump_active,
    output logic [NUM_OBS-1:0] obs_spawn,
    output logic [NUM_OBS-1:0] obs_active,
    output logic               obs_drop,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hi_score
);

    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned JUMP_CYC = JUMP_TICKS * TICK_DIV;
    localparam int unsigned JUMP_W   = (JUMP_CYC > 1) ? $clog2(JUMP_CYC) : 1;
    localparam int unsigned CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    state_t             r_state;
    logic               r_play_q, r_view_q, r_ret_q, r_jump_q, r_pause_q;
    logic               r_clr_screen, r_draw_en;
    logic [CLR_W-1:0]   r_clr_cnt;
    logic [TICK_W-1:0]  r_tick_cnt;
    logic               r_tick;
    logic [SCORE_W-1:0] r_score;
    logic               r_jump_active;
    logic [JUMP_W-1:0]  r_jump_cnt;

    logic w_play_rise, w_view_rise, w_ret_rise, w_jump_rise, w_pause_rise;
    logic w_run, w_tick_hit, w_clr_game;

    assign w_play_rise  = play       & ~r_play_q;
    assign w_view_rise  = view_score & ~r_view_q;
    assign w_ret_rise   = ret        & ~r_ret_q;
    assign w_jump_rise  = jump       & ~r_jump_q;
    assign w_pause_rise = pause      & ~r_pause_q;

    // Game activity advances only on cycles that remain in GAME (not on lose / pause transitions)
    assign w_run      = (r_state == GAME) && !lose && !w_pause_rise;
    assign w_tick_hit = w_run && (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    assign w_clr_game = (r_state == S_RESET);

    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            r_play_q  <= 1'b0;
            r_view_q  <= 1'b0;
            r_ret_q   <= 1'b0;
            r_jump_q  <= 1'b0;
            r_pause_q <= 1'b0;
        end else begin
            r_play_q  <= play;
            r_view_q  <= view_score;
            r_ret_q   <= ret;
            r_jump_q  <= jump;
            r_pause_q <= pause;
        end
    end

    // Flow FSM; clr_screen and draw_en are set on the transitions into their states
    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= MENU;
            r_clr_screen <= 1'b0;
            r_draw_en    <= 1'b0;
            r_clr_cnt    <= '0;
        end else begin
            case (r_state)
                MENU: begin
                    if (w_view_rise)      r_state <= S_SCORE;
                    else if (w_play_rise) r_state <= S_RESET;
                end
                S_RESET: begin
                    r_state      <= S_GEN_SCREEN;
                    r_clr_screen <= 1'b1;
                    r_clr_cnt    <= '0;
                end
                S_GEN_SCREEN: begin
                    if (r_clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
                        r_state      <= GAME;
                        r_clr_screen <= 1'b0;
                        r_draw_en    <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + CLR_W'(1);
                    end
                end
                GAME: begin
                    if (lose) begin
                        r_state   <= S_CALC_HS;
                        r_draw_en <= 1'b0;
                    end else if (w_pause_rise) begin
                        r_state   <= PAUSE;
                        r_draw_en <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (w_pause_rise) begin
                        r_state   <= GAME;
                        r_draw_en <= 1'b1;
                    end
                end
                S_CALC_HS: r_state <= S_SCORE;
                S_SCORE: begin
                    if (w_ret_rise) r_state <= MENU;
                end
                default: begin
                    r_state      <= MENU;
                    r_clr_screen <= 1'b0;
                    r_draw_en    <= 1'b0;
                end
            endcase
        end
    end

    // Tick divider and saturating score; divider holds its count while not running
    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
            r_score    <= '0;
        end else begin
            r_tick <= 1'b0;
            if (w_clr_game) begin
                r_tick_cnt <= '0;
                r_score    <= '0;
            end else if (w_tick_hit) begin
                r_tick_cnt <= '0;
                r_tick     <= 1'b1;
                if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + SCORE_W'(1);
            end else if (w_run) begin
                r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
        end
    end

    // Jump timer counts JUMP_TICKS tick periods from the take-off cycle
    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            r_jump_active <= 1'b0;
            r_jump_cnt    <= '0;
        end else if (w_clr_game) begin
            r_jump_active <= 1'b0;
            r_jump_cnt    <= '0;
        end else if (w_run) begin
            if (r_jump_active) begin
                if (r_jump_cnt == JUMP_W'(JUMP_CYC - 1)) begin
                    r_jump_active <= 1'b0;
                    r_jump_cnt    <= '0;
                end else begin
                    r_jump_cnt <= r_jump_cnt + JUMP_W'(1);
                end
            end else if (w_jump_rise) begin
                r_jump_active <= 1'b1;
                r_jump_cnt    <= '0;
            end
        end
    end

`ifdef GAME_HISCORE_EN
    logic [SCORE_W-1:0] r_hi_score;

    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            r_hi_score <= '0;
        end else if ((r_state == S_CALC_HS) && (r_score > r_hi_score)) begin
            r_hi_score <= r_score;
        end
    end

    assign hi_score = r_hi_score;
`else
    assign hi_score = '0;
`endif

    obs_slot_alloc #(
        .NUM_OBS (NUM_OBS)
    ) u_obs_slot_alloc (
        .clk      (Clock),
        .rst_n    (resetn),
        .clr      (w_clr_game),
        .en       (w_run),
        .gen      (gen),
        .obs_done (obs_done),
        .spawn    (obs_spawn),
        .active   (obs_active),
        .drop     (obs_drop)
    );

    assign state       = r_state;
    assign clr_screen  = r_clr_screen;
    assign draw_en     = r_draw_en;
    assign tick        = r_tick;
    assign jump_active = r_jump_active;
    assign score       = r_score;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: timed level checks plus event queues for spawn/drop and ticks.
module tb_game_flow_ctrl;
    import game_pkg::*;

    localparam int NOBS = 2;
    localparam int SW   = 16;
    localparam int SEL_ST = 0, SEL_CLR = 1, SEL_DRAW = 2, SEL_JACT = 3;
    localparam int SEL_ACT = 4, SEL_SCORE = 5, SEL_HI = 6, SEL_ALL = 7;
`ifdef GAME_HISCORE_EN
    localparam logic [63:0] HI1 = 64'd7;
`else
    localparam logic [63:0] HI1 = 64'd0;
`endif

    logic            Clock = 1'b0;
    logic            resetn, play, view_score, ret, jump, pause, gen, lose;
    logic [NOBS-1:0] obs_done;
    logic [2:0]      state;
    logic            clr_screen, draw_en, tick, jump_active, obs_drop;
    logic [NOBS-1:0] obs_spawn, obs_active;
    logic [SW-1:0]   score, hi_score;

    game_flow_ctrl #(
        .SCORE_W(SW), .NUM_OBS(NOBS), .TICK_DIV(4), .JUMP_TICKS(3), .CLR_CYCLES(5)
    ) dut (
        .Clock(Clock), .resetn(resetn), .play(play), .view_score(view_score), .ret(ret),
        .jump(jump), .pause(pause), .gen(gen), .lose(lose), .obs_done(obs_done),
        .state(state), .clr_screen(clr_screen), .draw_en(draw_en), .tick(tick),
        .jump_active(jump_active), .obs_spawn(obs_spawn), .obs_active(obs_active),
        .obs_drop(obs_drop), .score(score), .hi_score(hi_score)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int          cyc;
        int          sel;
        logic [63:0] val;
        string       nm;
    } chk_t;

    chk_t            q_chk[$];
    logic [NOBS:0]   q_evt[$];   // {spawn, drop}
    logic [SW-1:0]   q_tick[$];  // score after each tick
    int              cyc = 0;
    int              n_vec = 0;
    int              n_miss = 0;
    int              c, g, c2, g2, p, c3, g3;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input int at, input int sel, input logic [63:0] val, input string nm);
        chk_t e;
        int   i;
        e.cyc = at; e.sel = sel; e.val = val; e.nm = nm;
        i = 0;
        while (i < q_chk.size() && q_chk[i].cyc <= at) i++;
        q_chk.insert(i, e);
    endtask

    task automatic wait_cyc(input int t);
        if (cyc > t) begin
            n_vec++; n_miss++;
            $display("FAIL sched: got cycle %0d, want <= %0d", cyc, t);
        end
        while (cyc < t) @(negedge Clock);
    endtask

    function automatic logic [63:0] sample(input int sel);
        case (sel)
            SEL_ST:    return 64'(state);
            SEL_CLR:   return 64'(clr_screen);
            SEL_DRAW:  return 64'(draw_en);
            SEL_JACT:  return 64'(jump_active);
            SEL_ACT:   return 64'(obs_active);
            SEL_SCORE: return 64'(score);
            SEL_HI:    return 64'(hi_score);
            default:   return 64'({state, clr_screen, draw_en, tick, jump_active,
                                   obs_spawn, obs_active, obs_drop, score, hi_score});
        endcase
    endfunction

    // Monitor: timed checks, then spawn/drop and tick events as the DUT presents them
    always @(negedge Clock) begin
        chk_t          e;
        logic [63:0]   act;
        logic [NOBS:0] ev;
        while (q_chk.size() > 0 && q_chk[0].cyc <= cyc) begin
            e   = q_chk.pop_front();
            act = sample(e.sel);
            n_vec++;
            if (e.cyc != cyc || act != e.val) begin
                n_miss++;
                $display("FAIL %s: got %0h, want %0h (cycle %0d, due %0d)", e.nm, act, e.val, cyc, e.cyc);
            end
        end
        if (obs_spawn != '0 || obs_drop) begin
            n_vec++;
            if (q_evt.size() == 0) begin
                n_miss++;
                $display("FAIL obs_evt: got spawn=%b drop=%b, want no event (cycle %0d)", obs_spawn, obs_drop, cyc);
            end else begin
                ev = q_evt.pop_front();
                if ({obs_spawn, obs_drop} != ev) begin
                    n_miss++;
                    $display("FAIL obs_evt: got spawn=%b drop=%b, want spawn=%b drop=%b (cycle %0d)",
                             obs_spawn, obs_drop, ev[NOBS:1], ev[0], cyc);
                end
            end
        end
        if (tick) begin
            n_vec++;
            if (q_tick.size() == 0) begin
                n_miss++;
                $display("FAIL tick_evt: got tick with score %0d, want no tick (cycle %0d)", score, cyc);
            end else if (score != q_tick[0]) begin
                n_miss++;
                $display("FAIL tick_evt: got score %0d, want %0d (cycle %0d)", score, q_tick[0], cyc);
                void'(q_tick.pop_front());
            end else begin
                void'(q_tick.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got time %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; play = 1'b0; view_score = 1'b0; ret = 1'b0; jump = 1'b0;
        pause = 1'b0; gen = 1'b0; lose = 1'b0; obs_done = '0;
        repeat (2) @(negedge Clock);
        resetn = 1'b1;
        chk(cyc + 1, SEL_ALL, 64'd0, "reset_all0");
        chk(cyc + 1, SEL_ST, 64'(MENU), "reset_menu");
        @(negedge Clock);

        // Game 1: screen clear, ticks, jump, obstacles, pause, lose at score 7
        c = cyc; g = c + 7;
        chk(c + 1, SEL_ST, 64'(S_RESET), "g1_sreset");
        chk(c + 1, SEL_CLR, 64'd0, "clr_pre");
        chk(c + 2, SEL_CLR, 64'd1, "clr_first");
        chk(c + 6, SEL_CLR, 64'd1, "clr_last");
        chk(c + 6, SEL_DRAW, 64'd0, "draw_pre");
        chk(g, SEL_CLR, 64'd0, "clr_off");
        chk(g, SEL_ST, 64'(GAME), "g1_game");
        chk(g, SEL_DRAW, 64'd1, "draw_game");
        chk(g + 3, SEL_SCORE, 64'd0, "score_t0");
        chk(g + 4, SEL_SCORE, 64'd1, "score_t1");
        chk(g + 8, SEL_SCORE, 64'd2, "score_t2");
        chk(g + 1, SEL_JACT, 64'd0, "jump_pre");
        chk(g + 2, SEL_JACT, 64'd1, "jump_up");
        chk(g + 13, SEL_JACT, 64'd1, "jump_last");
        chk(g + 14, SEL_JACT, 64'd0, "jump_down");
        chk(g + 16, SEL_ACT, 64'd1, "act_01");
        chk(g + 17, SEL_ACT, 64'd3, "act_11");
        chk(g + 19, SEL_ACT, 64'd2, "act_done0");
        chk(g + 20, SEL_ACT, 64'd3, "act_refill");
        chk(g + 22, SEL_ACT, 64'd0, "act_clear");
        chk(g + 24, SEL_ACT, 64'd0, "act_free_done");
        chk(g + 24, SEL_SCORE, 64'd6, "score_t6");
        chk(g + 26, SEL_ST, 64'(PAUSE), "pause_in");
        chk(g + 26, SEL_DRAW, 64'd0, "draw_pause");
        chk(g + 37, SEL_ST, 64'(PAUSE), "pause_lose_ign");
        chk(g + 42, SEL_JACT, 64'd0, "pause_jump_ign");
        chk(g + 42, SEL_ACT, 64'd0, "pause_gen_ign");
        chk(g + 45, SEL_ST, 64'(PAUSE), "pause_hold");
        chk(g + 45, SEL_SCORE, 64'd6, "pause_frozen");
        chk(g + 46, SEL_ST, 64'(GAME), "pause_out");
        chk(g + 46, SEL_DRAW, 64'd1, "draw_resume");
        chk(g + 48, SEL_SCORE, 64'd6, "resume_pre");
        chk(g + 49, SEL_SCORE, 64'd7, "resume_tick");
        chk(g + 51, SEL_ST, 64'(S_CALC_HS), "g1_calc");
        chk(g + 51, SEL_DRAW, 64'd0, "draw_lose");
        chk(g + 52, SEL_ST, 64'(S_SCORE), "g1_score_st");
        chk(g + 52, SEL_HI, HI1, "g1_hi");
        chk(g + 54, SEL_SCORE, 64'd7, "g1_score_hold");
        chk(g + 55, SEL_ST, 64'(MENU), "g1_ret");
        chk(g + 56, SEL_SCORE, 64'd7, "menu_score_hold");
        q_evt.push_back(3'b010);
        q_evt.push_back(3'b100);
        q_evt.push_back(3'b001);
        q_evt.push_back(3'b001);
        q_evt.push_back(3'b010);
        for (int s = 1; s <= 7; s++) q_tick.push_back(SW'(s));

        play = 1'b1;
        wait_cyc(c + 1);  play = 1'b0;
        wait_cyc(g + 1);  jump = 1'b1;
        wait_cyc(g + 2);  jump = 1'b0;
        wait_cyc(g + 5);  jump = 1'b1;
        wait_cyc(g + 7);  jump = 1'b0;
        wait_cyc(g + 15); gen = 1'b1;
        wait_cyc(g + 18); obs_done = 2'b01;
        wait_cyc(g + 19); obs_done = 2'b00;
        wait_cyc(g + 20); gen = 1'b0;
        wait_cyc(g + 21); obs_done = 2'b11;
        wait_cyc(g + 22); obs_done = 2'b01;
        wait_cyc(g + 23); obs_done = 2'b00;
        wait_cyc(g + 25); pause = 1'b1;
        wait_cyc(g + 26); pause = 1'b0;
        wait_cyc(g + 35); lose = 1'b1;
        wait_cyc(g + 36); lose = 1'b0;
        wait_cyc(g + 40); gen = 1'b1; jump = 1'b1;
        wait_cyc(g + 41); gen = 1'b0; jump = 1'b0;
        wait_cyc(g + 45); pause = 1'b1;
        wait_cyc(g + 46); pause = 1'b0;
        wait_cyc(g + 50); lose = 1'b1;
        wait_cyc(g + 51); lose = 1'b0;
        wait_cyc(g + 54); ret = 1'b1;
        wait_cyc(g + 55); ret = 1'b0;
        wait_cyc(g + 58);

        // Game 2: lose at score 3, high score must not drop
        c2 = cyc; g2 = c2 + 7;
        chk(c2 + 2, SEL_SCORE, 64'd0, "g2_clear");
        chk(c2 + 2, SEL_HI, HI1, "g2_hi_start");
        chk(g2 + 12, SEL_SCORE, 64'd3, "g2_score3");
        chk(g2 + 14, SEL_ST, 64'(S_CALC_HS), "g2_calc");
        chk(g2 + 15, SEL_ST, 64'(S_SCORE), "g2_score_st");
        chk(g2 + 16, SEL_HI, HI1, "hi_keep");
        chk(g2 + 16, SEL_SCORE, 64'd3, "g2_score_hold");
        chk(g2 + 18, SEL_ST, 64'(MENU), "g2_ret");
        for (int s = 1; s <= 3; s++) q_tick.push_back(SW'(s));
        play = 1'b1;
        wait_cyc(c2 + 1);  play = 1'b0;
        wait_cyc(g2 + 13); lose = 1'b1;
        wait_cyc(g2 + 14); lose = 1'b0;
        wait_cyc(g2 + 17); ret = 1'b1;
        wait_cyc(g2 + 18); ret = 1'b0;
        wait_cyc(g2 + 20);

        // view_score wins over play in MENU
        p = cyc;
        chk(p + 1, SEL_ST, 64'(S_SCORE), "menu_prio");
        chk(p + 4, SEL_ST, 64'(MENU), "prio_ret");
        view_score = 1'b1; play = 1'b1;
        wait_cyc(p + 1); view_score = 1'b0; play = 1'b0;
        wait_cyc(p + 3); ret = 1'b1;
        wait_cyc(p + 4); ret = 1'b0;
        wait_cyc(p + 6);

        // Game 3: asynchronous reset in mid-game, then restart
        c3 = cyc; g3 = c3 + 7;
        chk(g3 + 3, SEL_JACT, 64'd1, "g3_jump");
        chk(g3 + 3, SEL_ACT, 64'd1, "g3_act");
        chk(g3 + 5, SEL_SCORE, 64'd1, "g3_score1");
        q_evt.push_back(3'b010);
        q_tick.push_back(SW'(1));
        play = 1'b1;
        wait_cyc(c3 + 1); play = 1'b0;
        wait_cyc(g3 + 1); jump = 1'b1; gen = 1'b1;
        wait_cyc(g3 + 2); jump = 1'b0; gen = 1'b0;
        wait_cyc(g3 + 6);
        @(posedge Clock);
        #1;
        resetn = 1'b0;
        chk(cyc, SEL_ALL, 64'd0, "async_rst");
        wait_cyc(g3 + 8); resetn = 1'b1;
        chk(g3 + 9, SEL_ALL, 64'd0, "rst_release");
        wait_cyc(g3 + 9); play = 1'b1;
        chk(g3 + 10, SEL_ST, 64'(S_RESET), "post_rst_play");
        chk(g3 + 11, SEL_ST, 64'(S_GEN_SCREEN), "post_rst_gen");
        wait_cyc(g3 + 10); play = 1'b0;
        wait_cyc(g3 + 14);
        #1;

        n_vec++;
        if (q_chk.size() != 0) begin
            n_miss++;
            $display("FAIL chk_drain: got %0d pending, want 0", q_chk.size());
        end
        n_vec++;
        if (q_evt.size() != 0) begin
            n_miss++;
            $display("FAIL evt_drain: got %0d pending, want 0", q_evt.size());
        end
        n_vec++;
        if (q_tick.size() != 0) begin
            n_miss++;
            $display("FAIL tick_drain: got %0d pending, want 0", q_tick.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
